arm_regfile_mp: RTL and testbench
=================================

// Module: arm_regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the ARM core; next generation of the 2-read/1-write file.
//  N registered read ports; two write ports (A: ALU result, B: load result); BL link write; R15 reads as PC+8.
//  Per-register load-pending scoreboard reported on each read port, so decode can stall on loads in flight.
//  Sits between decode (read) and writeback (write) stages.
// PARAMETERS
//  DATA_W       32  register width
//  ADDR_W       4   register address width; NUM_REGS = 2**ADDR_W
//  NUM_RD       3   number of read ports (>=1)
//  PC_IDX       15  index of the PC register
//  LR_IDX       14  index of the link register
//  LINK_OFFSET  4   LR value = pc_plus8 - LINK_OFFSET
// PORTS
//  clk        in   1              clock; all state changes on posedge
//  reset      in   1              asynchronous, active-low reset
//  rd_addr    in   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_en      in   NUM_RD         read enable per port
//  rd_data    out  NUM_RD*DATA_W  registered read data
//  rd_busy    out  NUM_RD         registered pending flag of the register read
//  wa_en      in   1              write port A enable (ALU)
//  wa_addr    in   ADDR_W         write port A address
//  wa_data    in   DATA_W         write port A data
//  wb_en      in   1              write port B enable (load); also clears the pending bit
//  wb_addr    in   ADDR_W         write port B address
//  wb_data    in   DATA_W         write port B data
//  link_en    in   1              BL: write pc_plus8-LINK_OFFSET to LR_IDX
//  pc_plus8   in   DATA_W         current PC+8
//  pend_set   in   1              load issued: mark pend_addr pending
//  pend_addr  in   ADDR_W         destination register of the issued load
//  any_pend   out  1              registered OR of all pending bits
// BEHAVIOUR
//  - Reset (reset==0, async): all registers, pending bits, rd_data, rd_busy, any_pend = 0.
//  - Reads: latency 1. On the posedge with rd_en[k]=1, rd_data[k] <= value(rd_addr[k]) and
//    rd_busy[k] <= pending(rd_addr[k]). With rd_en[k]=0, both hold their previous value.
//  - PC_IDX reads return the pc_plus8 sampled that edge. rd_busy for PC_IDX is always 0.
//  - Write to PC_IDX on any port is dropped. The pend_set to PC_IDX is ignored.
//  - Write priority per register in one cycle: port A > link > port B. The loser is discarded.
//    Port B still clears the pending bit even when it loses.
//  - Link value = (pc_plus8 - LINK_OFFSET) mod 2**DATA_W; wraps at 0.
//  - Scoreboard: pend_set sets bit[pend_addr]; wb_en clears bit[wb_addr].
//    Set and clear to the same address in the same cycle: set wins.
//  - any_pend <= OR of the next-state pending bits.
//  - Read-during-write, same cycle and address: see CONFIGURATION.
//  - Reset asserted mid-operation: all state clears immediately; in-flight writes are lost.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - A read sees the winning same-cycle write data (write-through).
//   - rd_busy reflects the pending bit after the same-cycle wb clear and pend_set.
//  REGFILE_BYPASS_EN undefined:
//   - A read sees the pre-write register value and pre-update pending bit.
//   - Writeback must then precede the dependent read by one cycle.
// STRUCTURE
//  Package arm_rf_pkg:
//   - typedefs word_t [DATA_W-1:0] and reg_addr_t [ADDR_W-1:0]
//   - constants PC_IDX, LR_IDX, LINK_OFFSET
//   - function wr_sel() implementing the A > link > B priority
//  Sub-module arm_rf_read_port:
//   - one read mux, PC substitution, bypass compare and busy lookup
//   - instantiated NUM_RD times in a generate loop
//  Top level holds the register array, the write arbitration and the pending vector.
// TESTING
//  1. Reset release, then read all 16 regs -> rd_data = 0 (R15 = pc_plus8), rd_busy = 0, any_pend = 0.
//  2. wa writes R3=0x1234, next cycle read R3 on ports 0..2 -> all ports 0x1234 one cycle later.
//  3. Same cycle: wa R5=0xA, wb R5=0xB -> R5=0xA. Same cycle: link_en with wb R14=0x7, pc_plus8=0x108
//     -> R14=0x104. link_en with pc_plus8=0x2 -> R14=0xFFFFFFFE.
//  4. pend_set R7 -> rd_busy=1 and any_pend=1. Then wb R7=0x55 while reading R7:
//     bypass on -> rd_data 0x55, busy 0; bypass off -> old value, busy 1.
//  5. pend_set R2 and wb_en R2 in the same cycle -> R2 written, pending stays 1.
//     wa_en to R15=0xDEAD -> read R15 returns pc_plus8.
//  6. Assert reset mid-stream with R4 pending and rd_data non-zero -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/arm_regfile_mp_pkg.sv
// Shared types, default geometry and write-priority helper for the multi-port
// ARM register file.
// Contents: word_t / reg_addr_t typedefs, PC/LR/link constants, wr_sel().
package arm_rf_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned NUM_RD      = 3;
    localparam int unsigned PC_IDX      = 15;
    localparam int unsigned LR_IDX      = 14;
    localparam int unsigned LINK_OFFSET = 4;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    // Which source lands in a register this cycle
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_LINK = 2'd2,
        SEL_B    = 2'd3
    } wr_sel_e;

    // Same-register write arbitration: port A beats link beats port B
    function automatic wr_sel_e wr_sel(input logic hit_a,
                                       input logic hit_link,
                                       input logic hit_b);
        if (hit_a)         return SEL_A;
        else if (hit_link) return SEL_LINK;
        else if (hit_b)    return SEL_B;
        else               return SEL_NONE;
    endfunction

endpackage

// File: rtl/arm_regfile_mp_if.sv
// Decode/writeback bus of the multi-port register file.
// master: decode/writeback side (drives addresses, writes, pend_set)
// slave : register file (drives rd_data, rd_busy, any_pend)
interface arm_regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NUM_RD = 3
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wa_en;
    logic [ADDR_W-1:0]        wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     link_en;
    logic [DATA_W-1:0]        pc_plus8;
    logic                     pend_set;
    logic [ADDR_W-1:0]        pend_addr;
    logic                     any_pend;

    modport master (
        output rd_addr, rd_en, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               link_en, pc_plus8, pend_set, pend_addr,
        input  rd_data, rd_busy, any_pend
    );

    modport slave (
        input  rd_addr, rd_en, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               link_en, pc_plus8, pend_set, pend_addr,
        output rd_data, rd_busy, any_pend
    );
endinterface

// File: rtl/arm_regfile_mp_read_port.sv
// One registered read port: register mux, PC substitution, optional
// same-cycle write bypass and load-pending lookup.
// Optional feature macro: REGFILE_BYPASS_EN (write-through reads when defined).
// Ports: clk, reset (async active-low), en/addr (read request),
//        regs/pend (current file state), write-side signals (bypass only),
//        data/busy (registered read result).
module arm_rf_read_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PC_IDX = 15,
    parameter int unsigned LR_IDX = 14
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [ADDR_W-1:0]              addr,
    input  logic [(2**ADDR_W)*DATA_W-1:0]  regs,
    input  logic [(2**ADDR_W)-1:0]         pend,
    input  logic [DATA_W-1:0]              pc_plus8,
    input  logic                           wa_en,
    input  logic [ADDR_W-1:0]              wa_addr,
    input  logic [DATA_W-1:0]              wa_data,
    input  logic                           link_en,
    input  logic [DATA_W-1:0]              link_data,
    input  logic                           wb_en,
    input  logic [ADDR_W-1:0]              wb_addr,
    input  logic [DATA_W-1:0]              wb_data,
    input  logic                           pend_set,
    input  logic [ADDR_W-1:0]              pend_addr,
    output logic [DATA_W-1:0]              data,
    output logic                           busy
);
    import arm_rf_pkg::*;

    localparam int unsigned NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0] reg_arr [NUM_REGS];
    logic [DATA_W-1:0] data_c;
    logic              busy_c;

    // Unpack the flat register bus for a clean address mux
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
        assign reg_arr[g] = regs[g*DATA_W +: DATA_W];
    end

    // Next read value and busy flag for the addressed register
    always_comb begin
        data_c = reg_arr[addr];
        busy_c = pend[addr];
`ifdef REGFILE_BYPASS_EN
        case (wr_sel(wa_en && (wa_addr == addr),
                     link_en && (addr == ADDR_W'(LR_IDX)),
                     wb_en && (wb_addr == addr)))
            SEL_A:    data_c = wa_data;
            SEL_LINK: data_c = link_data;
            SEL_B:    data_c = wb_data;
            default:  data_c = reg_arr[addr];
        endcase
        // Clear then set, so a same-cycle pend_set wins
        if (wb_en && (wb_addr == addr))       busy_c = 1'b0;
        if (pend_set && (pend_addr == addr))  busy_c = 1'b1;
`endif
        // PC always reads as the live pc_plus8 and is never pending
        if (addr == ADDR_W'(PC_IDX)) begin
            data_c = pc_plus8;
            busy_c = 1'b0;
        end
    end

`ifndef REGFILE_BYPASS_EN
    // Write-side inputs only matter for write-through reads
    logic unused_bypass;
    assign unused_bypass = ^{wa_en, wa_addr, wa_data, link_en, link_data,
                             wb_en, wb_addr, wb_data, pend_set, pend_addr};
`endif

    // Read result register; holds while the port is idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
            busy <= 1'b0;
        end else if (en) begin
            data <= data_c;
            busy <= busy_c;
        end
    end

endmodule

// File: rtl/arm_regfile_mp.sv
// Multi-port ARM register file: NUM_RD registered read ports, ALU (A) and
// load (B) write ports, BL link write, PC-as-pc_plus8 reads and a per-register
// load-pending scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through reads).
// Ports: clk, reset (async active-low), bus (arm_regfile_mp_if.slave).
module arm_regfile_mp #(
    parameter int unsigned DATA_W      = arm_rf_pkg::DATA_W,
    parameter int unsigned ADDR_W      = arm_rf_pkg::ADDR_W,
    parameter int unsigned NUM_RD      = arm_rf_pkg::NUM_RD,
    parameter int unsigned PC_IDX      = arm_rf_pkg::PC_IDX,
    parameter int unsigned LR_IDX      = arm_rf_pkg::LR_IDX,
    parameter int unsigned LINK_OFFSET = arm_rf_pkg::LINK_OFFSET
) (
    input  logic           clk,
    input  logic           reset,
    arm_regfile_mp_if.slave bus
);
    import arm_rf_pkg::*;

    localparam int unsigned NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]          regs     [NUM_REGS];
    logic [DATA_W-1:0]          regs_nxt [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        pend;
    logic [NUM_REGS-1:0]        pend_nxt;
    logic [DATA_W-1:0]          link_data_c;
    logic                       any_pend_q;

    // BL return address; modular subtraction wraps below zero
    assign link_data_c = bus.pc_plus8 - DATA_W'(LINK_OFFSET);

    // Per-register write arbitration; PC is never written
    always_comb begin
        regs_nxt = regs;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (i != PC_IDX) begin
                case (wr_sel(bus.wa_en && (bus.wa_addr == ADDR_W'(i)),
                             bus.link_en && (i == LR_IDX),
                             bus.wb_en && (bus.wb_addr == ADDR_W'(i))))
                    SEL_A:    regs_nxt[i] = bus.wa_data;
                    SEL_LINK: regs_nxt[i] = link_data_c;
                    SEL_B:    regs_nxt[i] = bus.wb_data;
                    default:  regs_nxt[i] = regs[i];
                endcase
            end
        end
    end

    // Scoreboard update: load writeback clears, load issue sets (set wins)
    always_comb begin
        pend_nxt = pend;
        if (bus.wb_en)
            pend_nxt[bus.wb_addr] = 1'b0;
        if (bus.pend_set && (bus.pend_addr != ADDR_W'(PC_IDX)))
            pend_nxt[bus.pend_addr] = 1'b1;
    end

    // Register array, scoreboard and summary flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            pend       <= '0;
            any_pend_q <= 1'b0;
        end else begin
            regs       <= regs_nxt;
            pend       <= pend_nxt;
            any_pend_q <= |pend_nxt;
        end
    end

    assign bus.any_pend = any_pend_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

    // One independent read port per decode operand
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        arm_rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .PC_IDX (PC_IDX),
            .LR_IDX (LR_IDX)
        ) u_rd (
            .clk       (clk),
            .reset     (reset),
            .en        (bus.rd_en[k]),
            .addr      (bus.rd_addr[k*ADDR_W +: ADDR_W]),
            .regs      (regs_flat),
            .pend      (pend),
            .pc_plus8  (bus.pc_plus8),
            .wa_en     (bus.wa_en),
            .wa_addr   (bus.wa_addr),
            .wa_data   (bus.wa_data),
            .link_en   (bus.link_en),
            .link_data (link_data_c),
            .wb_en     (bus.wb_en),
            .wb_addr   (bus.wb_addr),
            .wb_data   (bus.wb_data),
            .pend_set  (bus.pend_set),
            .pend_addr (bus.pend_addr),
            .data      (bus.rd_data[k*DATA_W +: DATA_W]),
            .busy      (bus.rd_busy[k])
        );
    end

endmodule

// File: tb/tb_arm_regfile_mp.sv
// Self-checking bench for arm_regfile_mp: directed scenarios followed by
// random traffic, checked against an array-based reference model.
// Honours REGFILE_BYPASS_EN the same way as the design.
module tb_arm_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 3;
    localparam int NREG = 16;
    localparam int PC = 15;
    localparam int LR = 14;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    arm_regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    arm_regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
        .PC_IDX(PC), .LR_IDX(LR), .LINK_OFFSET(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors;
    int checks;

    logic [31:0] m_regs [NREG];
    bit          m_pend [NREG];
    logic [31:0] exp_data [NR];
    bit          exp_busy [NR];
    bit          exp_any;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        for (int k = 0; k < NR; k++) begin
            exp_data[k] = '0;
            exp_busy[k] = 1'b0;
        end
        exp_any = 1'b0;
    endtask

    task automatic idle();
        bus.rd_en     = '0;
        bus.rd_addr   = '0;
        bus.wa_en     = 1'b0;
        bus.wa_addr   = '0;
        bus.wa_data   = '0;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.link_en   = 1'b0;
        bus.pend_set  = 1'b0;
        bus.pend_addr = '0;
    endtask

    task automatic rd(input int k, input int a);
        bus.rd_en[k] = 1'b1;
        bus.rd_addr[k*AW +: AW] = AW'(a);
    endtask

    function automatic logic [31:0] port_data(input int k);
        logic [NR*DW-1:0] v;
        v = bus.rd_data;
        return v[k*DW +: DW];
    endfunction

    // Predict one clock from the architectural rules, clock, then compare
    task automatic clk_step();
        logic [31:0] n_regs [NREG];
        bit          n_pend [NREG];
        int          a;
        n_regs = m_regs;
        n_pend = m_pend;
        // Apply lowest priority first so higher-priority writes overwrite
        if (bus.wb_en && int'(bus.wb_addr) != PC) n_regs[bus.wb_addr] = bus.wb_data;
        if (bus.link_en) n_regs[LR] = bus.pc_plus8 - 32'd4;
        if (bus.wa_en && int'(bus.wa_addr) != PC) n_regs[bus.wa_addr] = bus.wa_data;
        if (bus.wb_en) n_pend[bus.wb_addr] = 1'b0;
        if (bus.pend_set && int'(bus.pend_addr) != PC) n_pend[bus.pend_addr] = 1'b1;
        for (int k = 0; k < NR; k++) begin
            if (bus.rd_en[k]) begin
                a = int'(bus.rd_addr[k*AW +: AW]);
                if (a == PC) begin
                    exp_data[k] = bus.pc_plus8;
                    exp_busy[k] = 1'b0;
                end else begin
`ifdef REGFILE_BYPASS_EN
                    exp_data[k] = n_regs[a];
                    exp_busy[k] = n_pend[a];
`else
                    exp_data[k] = m_regs[a];
                    exp_busy[k] = m_pend[a];
`endif
                end
            end
        end
        exp_any = 1'b0;
        for (int i = 0; i < NREG; i++) exp_any |= n_pend[i];
        @(posedge clk);
        #1;
        m_regs = n_regs;
        m_pend = n_pend;
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("rd_data[%0d]", k), port_data(k), exp_data[k]);
            chk($sformatf("rd_busy[%0d]", k), 32'(bus.rd_busy[k]), 32'(exp_busy[k]));
        end
        chk("any_pend", 32'(bus.any_pend), 32'(exp_any));
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < NR; k++) begin
            chk({tag, "_data"}, port_data(k), 32'h0);
            chk({tag, "_busy"}, 32'(bus.rd_busy[k]), 32'h0);
        end
        chk({tag, "_any"}, 32'(bus.any_pend), 32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        idle();
        bus.pc_plus8 = 32'h0000_1000;
        model_clear();

        // Reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // All registers read as zero, R15 as pc_plus8
        for (int r = 0; r < NREG; r++) begin
            idle();
            rd(0, r);
            rd(1, (r + 5) % NREG);
            rd(2, (r + 10) % NREG);
            clk_step();
        end

        // ALU write then read on all ports
        idle();
        bus.wa_en = 1'b1; bus.wa_addr = 4'd3; bus.wa_data = 32'h1234;
        clk_step();
        idle();
        rd(0, 3); rd(1, 3); rd(2, 3);
        clk_step();
        for (int k = 0; k < NR; k++) chk("r3_all_ports", port_data(k), 32'h1234);

        // Port A beats port B on the same register
        idle();
        bus.wa_en = 1'b1; bus.wa_addr = 4'd5; bus.wa_data = 32'hA;
        bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 32'hB;
        clk_step();
        idle(); rd(0, 5);
        clk_step();
        chk("a_over_b", port_data(0), 32'hA);

        // Link beats port B on LR
        idle();
        bus.pc_plus8 = 32'h108;
        bus.link_en = 1'b1;
        bus.wb_en = 1'b1; bus.wb_addr = 4'd14; bus.wb_data = 32'h7;
        clk_step();
        idle(); rd(1, 14);
        clk_step();
        chk("link_over_b", port_data(1), 32'h104);

        // Link value wraps below zero
        idle();
        bus.pc_plus8 = 32'h2;
        bus.link_en = 1'b1;
        clk_step();
        idle(); rd(2, 14);
        clk_step();
        chk("link_wrap", port_data(2), 32'hFFFF_FFFE);

        // Load pending on R7
        idle();
        bus.pend_set = 1'b1; bus.pend_addr = 4'd7;
        clk_step();
        idle(); rd(0, 7);
        clk_step();
        chk("r7_busy", 32'(bus.rd_busy[0]), 32'h1);
        chk("r7_any", 32'(bus.any_pend), 32'h1);

        // Load writeback to R7 while reading R7
        idle();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 32'h55;
        rd(0, 7);
        clk_step();
`ifdef REGFILE_BYPASS_EN
        chk("rdw_data", port_data(0), 32'h55);
        chk("rdw_busy", 32'(bus.rd_busy[0]), 32'h0);
`else
        chk("rdw_data", port_data(0), 32'h0);
        chk("rdw_busy", 32'(bus.rd_busy[0]), 32'h1);
`endif
        idle(); rd(0, 7);
        clk_step();
        chk("r7_after_wb", port_data(0), 32'h55);
        chk("r7_cleared", 32'(bus.rd_busy[0]), 32'h0);

        // Set and clear on the same register: set wins, data still written
        idle();
        bus.pend_set = 1'b1; bus.pend_addr = 4'd2;
        bus.wb_en = 1'b1; bus.wb_addr = 4'd2; bus.wb_data = 32'h22;
        clk_step();
        idle(); rd(1, 2);
        clk_step();
        chk("r2_data", port_data(1), 32'h22);
        chk("r2_busy", 32'(bus.rd_busy[1]), 32'h1);

        // Writes to PC are dropped; PC reads track pc_plus8
        idle();
        bus.pc_plus8 = 32'h2000;
        bus.wa_en = 1'b1; bus.wa_addr = 4'd15; bus.wa_data = 32'hDEAD;
        bus.pend_set = 1'b1; bus.pend_addr = 4'd15;
        rd(0, 15);
        clk_step();
        chk("pc_read0", port_data(0), 32'h2000);
        idle();
        bus.pc_plus8 = 32'h3000;
        rd(0, 15);
        clk_step();
        chk("pc_read1", port_data(0), 32'h3000);
        chk("pc_busy", 32'(bus.rd_busy[0]), 32'h0);

        // Asynchronous reset mid-stream
        idle();
        bus.pend_set = 1'b1; bus.pend_addr = 4'd4;
        rd(0, 3);
        clk_step();
        chk("pre_reset_data", port_data(0), 32'h1234);
        idle();
        bus.wa_en = 1'b1; bus.wa_addr = 4'd9; bus.wa_data = 32'h99;
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_clear();
        idle();
        #3;
        reset = 1'b1;
        rd(0, 3); rd(1, 4); rd(2, 9);
        clk_step();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            bus.pc_plus8  = $urandom();
            bus.rd_en     = NR'($urandom_range(0, 7));
            for (int k = 0; k < NR; k++) bus.rd_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
            bus.wa_en     = ($urandom_range(0, 2) == 0);
            bus.wa_addr   = AW'($urandom_range(0, 15));
            bus.wa_data   = $urandom();
            bus.wb_en     = ($urandom_range(0, 2) == 0);
            bus.wb_addr   = AW'($urandom_range(0, 15));
            bus.wb_data   = $urandom();
            bus.link_en   = ($urandom_range(0, 5) == 0);
            bus.pend_set  = ($urandom_range(0, 3) == 0);
            bus.pend_addr = AW'($urandom_range(0, 15));
            clk_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
